fb_pwrite: RTL

- Framebuffer pixel writer: the consumer end of the line and fill drawers' `x/valid/oe` output handshake.
- Accepts signed pixel coordinates plus colour from a drawing engine, clips them to the canvas, and computes a linear framebuffer address.
- Buffers accepted pixels and issues them to a single framebuffer write port that can stall.
- Sits between the gfx drawers and the framebuffer memory arbiter. Drives `oe` back to the drawer and reports draw completion once every pixel has actually been written.

---
 rtl/fb_pwrite_pkg.sv | 23 ++
 rtl/fb_pwrite_if.sv | 32 +++
 rtl/fb_pfifo.sv | 39 +++
 rtl/fb_pwrite.sv | 110 +++++++++++
 4 files changed

// File: rtl/fb_pwrite_pkg.sv
// Shared gfx definitions: default widths, canvas geometry and the clip test.
package fb_pwrite_pkg;

  localparam int CORDW_D  = 16;
  localparam int COLRW_D  = 8;
  localparam int ADDRW_D  = 17;
  localparam int WIDTH_D  = 320;
  localparam int HEIGHT_D = 240;
  localparam int BASE_D   = 0;
  localparam int DEPTH_D  = 4;

  // Completion tracking after the drawer signals the end of a shape.
  typedef enum logic {
    DRAW_IDLE  = 1'b0,
    DRAW_FLUSH = 1'b1
  } draw_st_e;

  // True when a signed coordinate lies outside a w x h canvas.
  function automatic logic clip_test(input int x, input int y, input int w, input int h);
    return (x < 0) || (x >= w) || (y < 0) || (y >= h);
  endfunction

endpackage

// File: rtl/fb_pwrite_if.sv
// Drawer-side handshake, framebuffer write port and status of the pixel writer.
interface fb_pwrite_if
  import fb_pwrite_pkg::*;
#(
  parameter int CORDW = CORDW_D,
  parameter int COLRW = COLRW_D,
  parameter int ADDRW = ADDRW_D
);
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic [COLRW-1:0]        colr;
  logic                    valid;
  logic                    oe;
  logic                    draw_done;
  logic                    mem_we;
  logic [ADDRW-1:0]        mem_addr;
  logic [COLRW-1:0]        mem_data;
  logic                    mem_ready;
  logic                    busy;
  logic                    done;
  logic [15:0]             cnt_clip;

  modport master (
    output x, y, colr, valid, draw_done, mem_ready,
    input  oe, mem_we, mem_addr, mem_data, busy, done, cnt_clip
  );

  modport slave (
    input  x, y, colr, valid, draw_done, mem_ready,
    output oe, mem_we, mem_addr, mem_data, busy, done, cnt_clip
  );
endinterface

// File: rtl/fb_pfifo.sv
// Small synchronous FIFO with occupancy count; head is visible combinationally.
module fb_pfifo #(
  parameter int DW    = 25,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  // Storage, pointers and count; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign dout = mem[rp];

endmodule

// File: rtl/fb_pwrite.sv
// Framebuffer pixel writer: clip, address, buffer and issue pixels to a stallable write port.
//
// state      | meaning
// DRAW_IDLE  | no draw_done outstanding
// DRAW_FLUSH | draw_done seen, waiting for S1 and FIFO to drain
module fb_pwrite
  import fb_pwrite_pkg::*;
#(
  parameter int CORDW  = CORDW_D,
  parameter int COLRW  = COLRW_D,
  parameter int ADDRW  = ADDRW_D,
  parameter int WIDTH  = WIDTH_D,
  parameter int HEIGHT = HEIGHT_D,
  parameter int BASE   = BASE_D,
  parameter int DEPTH  = DEPTH_D
) (
  input logic       clk,
  input logic       rst_n,
  fb_pwrite_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = ADDRW + COLRW;

  logic signed [CORDW-1:0] px, py;
  logic                    accept, clip, s1_valid_next, s1_valid, pop, oe_next, oe_q;
  logic [ADDRW-1:0]        addr_calc, s1_addr;
  logic [COLRW-1:0]        s1_colr;
  logic [CW-1:0]           fifo_count, fifo_count_next;
  logic                    fifo_empty;
  logic [DW-1:0]           head;
  logic [15:0]             cnt_clip_q;
  draw_st_e                st, st_next;
  logic                    done_next, done_q;

  assign px            = bus.x;
  assign py            = bus.y;
  assign accept        = bus.valid && oe_q;
  assign clip          = clip_test(int'(px), int'(py), WIDTH, HEIGHT);
  assign addr_calc     = ADDRW'(BASE + int'(py) * WIDTH + int'(px));
  assign s1_valid_next = accept && !clip;

  // S1: register the addressed pixel, count clipped ones with saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_colr    <= '0;
      cnt_clip_q <= '0;
    end else begin
      s1_valid <= s1_valid_next;
      if (s1_valid_next) begin
        s1_addr <= addr_calc;
        s1_colr <= bus.colr;
      end
      if (accept && clip && cnt_clip_q != 16'hFFFF) cnt_clip_q <= cnt_clip_q + 16'd1;
    end
  end

  fb_pfifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid),
    .din   ({s1_addr, s1_colr}),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count)
  );

  assign fifo_empty      = (fifo_count == '0);
  assign pop             = !fifo_empty && bus.mem_ready;
  assign fifo_count_next = fifo_count + CW'(s1_valid) - CW'(pop);
  // Threshold leaves one slot for the accept that lands while oe is still high.
  assign oe_next = ((CW+1)'(fifo_count_next) + (CW+1)'(s1_valid_next)) <= (CW+1)'(DEPTH - 2);

  // Completion next-state: drain after draw_done, extra draw_done while flushing is absorbed.
  always_comb begin
    st_next   = st;
    done_next = 1'b0;
    case (st)
      DRAW_IDLE:  if (bus.draw_done) st_next = DRAW_FLUSH;
      DRAW_FLUSH: if (!s1_valid && fifo_empty) begin
        st_next   = DRAW_IDLE;
        done_next = 1'b1;
      end
      default:    st_next = DRAW_IDLE;
    endcase
  end

  // Control registers: completion state, done pulse and drawer output enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= DRAW_IDLE;
      done_q <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      st     <= st_next;
      done_q <= done_next;
      oe_q   <= oe_next;
    end
  end

  assign bus.oe       = oe_q;
  assign bus.mem_we   = !fifo_empty;
  assign bus.mem_addr = head[DW-1:COLRW];
  assign bus.mem_data = head[COLRW-1:0];
  assign bus.busy     = (st == DRAW_FLUSH) || s1_valid || !fifo_empty || accept;
  assign bus.done     = done_q;
  assign bus.cnt_clip = cnt_clip_q;

endmodule
